// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    // Wide all-ones anode pattern; callers slice it down to their digit count.
    function automatic logic [31:0] ANODE_OFF();
        return '1;
    endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex digit to active-low {dp,g..a} segment decoder for common-anode displays.
module seven_segment (
    input  logic [3:0] digit,
    input  logic       dp_enable,
    output logic [7:0] segments
);

    logic [6:0] pattern;

    always_comb begin
        pattern = 7'h7F;
        case (digit)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            4'hF: pattern = 7'h0E;
            default: pattern = 7'h7F;
        endcase
    end

    assign segments = {~dp_enable, pattern};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit scan controller with per-slot blanking and
// frame-aligned double buffering of the displayed value.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic [7:0]                segments,
    output logic                      frame_done
);

    localparam int CW = $clog2(TICKS_PER_DIGIT);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [31:0]           OFF_WIDE = ANODE_OFF();
    localparam logic [NUM_DIGITS-1:0] OFF_ALL  = OFF_WIDE[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] ONE_LOW  = NUM_DIGITS'(1);

    if (BLANK_TICKS >= TICKS_PER_DIGIT - 1) begin : g_bad_blank
        $error("seg_scan_ctrl: BLANK_TICKS must be < TICKS_PER_DIGIT-1");
    end

    scan_state_t             state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;

    logic [4*NUM_DIGITS-1:0] active_val, pend_val;
    logic [NUM_DIGITS-1:0]   active_dp, pend_dp;
    logic [NUM_DIGITS-1:0]   active_en, pend_en;
    logic                    pend_valid;

    logic                    slot_end, last_slot, boundary;
    logic [3:0]              cur_digit;
    logic                    cur_dp, cur_en;
    logic [7:0]              dec_seg;

    assign slot_end  = (cnt == CW'(TICKS_PER_DIGIT - 1));
    assign last_slot = (idx == IW'(NUM_DIGITS - 1));
    assign boundary  = slot_end && last_slot;

    assign cur_digit = active_val[4*idx +: 4];
    assign cur_dp    = active_dp[idx];
    assign cur_en    = active_en[idx];

    seven_segment u_dec (
        .digit     (cur_digit),
        .dp_enable (cur_dp),
        .segments  (dec_seg)
    );

    // Slot/digit counters, BLANK/SHOW state and the output registers, which
    // lag the state by one cycle so anodes and segments always move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            anodes     <= OFF_ALL;
            segments   <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt   <= '0;
                idx   <= last_slot ? '0 : idx + 1'b1;
                state <= ST_BLANK;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(BLANK_TICKS - 1))
                    state <= ST_SHOW;
            end

            if (state == ST_SHOW && cur_en) begin
                anodes   <= ~(ONE_LOW << idx);
                segments <= dec_seg;
            end else begin
                anodes   <= OFF_ALL;
                segments <= SEG_BLANK;
            end

            frame_done <= boundary;
        end
    end

    // A load on the boundary itself skips pending so it is not lost a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_val <= '0;
            active_dp  <= '0;
            active_en  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary && load) begin
            active_val <= value;
            active_dp  <= dp_mask;
            active_en  <= digit_en;
            pend_valid <= 1'b0;
        end else if (boundary && pend_valid) begin
            active_val <= pend_val;
            active_dp  <= pend_dp;
            active_en  <= pend_en;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_mask;
            pend_en    <= digit_en;
            pend_valid <= 1'b1;
        end
    end

endmodule
